// File: rtl/barker_correlator.sv
// ---------------------------------------------------------------------------
// barker_correlator
//
// Correlates each received 1-bit AXI-Stream frame against a Barker code,
// then thresholds the score. It emits one result beat per frame that carries
// the signed score and the detect and length-error flags. It also keeps a
// saturating count of the detections that downstream has accepted.
//
// Ports
//   i_clk            clock, rising edge
//   i_rst_n          synchronous reset, active-low
//   s_axis_tdata     received bit
//   s_axis_tvalid    input beat valid
//   s_axis_tlast     last bit of the frame
//   s_axis_tready    input accept (only while collecting)
//   m_axis_tdata     signed two's-complement correlation score
//   m_axis_tuser     bit0 = detect, bit1 = len_err
//   m_axis_tvalid    result valid
//   m_axis_tlast     high together with m_axis_tvalid (one beat per frame)
//   m_axis_tready    downstream accept
//   o_det_cnt        saturating count of accepted detect=1 results
// ---------------------------------------------------------------------------
module barker_correlator #(
  parameter int                 SEQ_LEN    = 11,
  parameter logic [SEQ_LEN-1:0] GOLDEN_SEQ = 11'b11100010010,
  parameter int                 THRESHOLD  = 9,
  parameter int                 SCORE_W    = 5,
  parameter int                 CNT_W      = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      s_axis_tdata,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  output logic                      s_axis_tready,
  output logic signed [SCORE_W-1:0] m_axis_tdata,
  output logic [1:0]                m_axis_tuser,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_tready,
  output logic [CNT_W-1:0]          o_det_cnt
);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_SCORE   = 2'd1,
    S_EMIT    = 2'd2
  } state_t;

  localparam logic [3:0]                LEN_BEATS = 4'(SEQ_LEN);
  localparam logic signed [SCORE_W-1:0] THR       = SCORE_W'(THRESHOLD);
  localparam logic signed [SCORE_W-1:0] ONE       = SCORE_W'(1);

  state_t                     state, state_next;
  logic [SEQ_LEN-1:0]         sr;
  logic [3:0]                 bcnt;
  logic                       in_fire;
  logic signed [SCORE_W-1:0]  score;
  logic                       len_err;
  logic                       detect;

  // +1 for every bit that matches the reference, -1 for every bit that differs.
  function automatic logic signed [SCORE_W-1:0] corr_score(input logic [SEQ_LEN-1:0] bits);
    logic signed [SCORE_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (bits[i] == GOLDEN_SEQ[i]) acc = acc + ONE;
      else                          acc = acc - ONE;
    end
    return acc;
  endfunction

  function automatic logic [3:0] sat_inc_beats(input logic [3:0] v);
    return (&v) ? v : v + 4'd1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign in_fire = s_axis_tvalid && s_axis_tready;
  assign score   = corr_score(sr);
  // bcnt already includes the tlast beat by the time S_SCORE is reached.
  assign len_err = (bcnt != LEN_BEATS);
  assign detect  = !len_err && (score >= THR);

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= S_COLLECT;
    else          state <= state_next;
  end

  // Next state and input-side handshake
  always_comb begin
    state_next    = state;
    s_axis_tready = 1'b0;
    unique case (state)
      S_COLLECT: begin
        // Held low during reset so that no beat appears accepted while reset is asserted.
        s_axis_tready = i_rst_n;
        if (s_axis_tvalid && s_axis_tlast) state_next = S_SCORE;
      end
      S_SCORE: state_next = S_EMIT;
      S_EMIT:  if (m_axis_tready) state_next = S_COLLECT;
      default: state_next = S_COLLECT;
    endcase
  end

  // Collect / score / emit datapath
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sr            <= '0;
      bcnt          <= '0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      o_det_cnt     <= '0;
    end else begin
      unique case (state)
        S_COLLECT: begin
          if (in_fire) begin
            sr   <= {sr[SEQ_LEN-2:0], s_axis_tdata};
            bcnt <= sat_inc_beats(bcnt);
          end
        end
        S_SCORE: begin
          m_axis_tdata  <= score;
          m_axis_tuser  <= {len_err, detect};
          m_axis_tvalid <= 1'b1;
          m_axis_tlast  <= 1'b1;
          // Clearing here zero-extends a following short frame.
          sr            <= '0;
          bcnt          <= '0;
        end
        S_EMIT: begin
          if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            if (m_axis_tuser[0]) o_det_cnt <= sat_inc_cnt(o_det_cnt);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
